// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, memory arbiter FSM states and
// request kinds, plus a pointer-width helper used by the arbiter blocks.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IRD  = 2'd1,
        DRD  = 2'd2,
        DWR  = 2'd3
    } req_kind_t;

    // Core-index width; a single-core build still keeps a 1-bit index.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: grants the first requesting core at or after the
// pointer, wrapping from the last core back to core 0.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic [CPUS-1:0]             i_req,
    input  logic [ptr_width(CPUS)-1:0]  i_ptr,
    output logic [CPUS-1:0]             o_grant,
    output logic                        o_valid
);

    localparam int PTR_W = ptr_width(CPUS);

    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % CPUS);
            if (i_req[w_idx]) begin
                o_grant = CPUS'(1) << w_idx;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates every core's fetch and data requests onto the single RAM port,
// holding the granted access in registers until RAM reports ACCESS.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  logic [1:0]           ramstate,
    output logic                 err_timeout
);

    localparam int PTR_W = ptr_width(CPUS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t       r_state, w_nxt_state;
    req_kind_t        r_kind, w_nxt_kind;
    logic [PTR_W-1:0] r_rr_ptr, w_nxt_rr;
    logic [PTR_W-1:0] r_owner, w_nxt_owner;
    word_t            r_addr, w_nxt_addr;
    word_t            r_store, w_nxt_store;
    logic             r_ren, w_nxt_ren;
    logic             r_wen, w_nxt_wen;
    logic [WD_W-1:0]  r_wdog;
    logic             r_err;

    logic [CPUS-1:0]  w_dreq;
    logic [CPUS-1:0]  w_dgrant, w_igrant;
    logic             w_dvalid, w_ivalid;
    logic [PTR_W-1:0] w_didx, w_iidx, w_owner_inc;
    logic             w_owner_req;
    logic             w_access;

    word_t w_iaddr_a  [CPUS];
    word_t w_daddr_a  [CPUS];
    word_t w_dstore_a [CPUS];

    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [CPUS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int n = 0; n < CPUS; n++) begin
            if (oh[n]) idx = PTR_W'(n);
        end
        return idx;
    endfunction

    for (genvar g = 0; g < CPUS; g++) begin : g_unpack
        assign w_iaddr_a[g]  = iaddr[g*32 +: 32];
        assign w_daddr_a[g]  = daddr[g*32 +: 32];
        assign w_dstore_a[g] = dstore[g*32 +: 32];
    end

    // Reads and writes share one class so data always outranks fetch.
    assign w_dreq = dREN | dWEN;

    rr_pick #(.CPUS(CPUS)) u_pick_data (
        .i_req   (w_dreq),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_dgrant),
        .o_valid (w_dvalid)
    );

    rr_pick #(.CPUS(CPUS)) u_pick_instr (
        .i_req   (iREN),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_igrant),
        .o_valid (w_ivalid)
    );

    assign w_didx      = oh_to_idx(w_dgrant);
    assign w_iidx      = oh_to_idx(w_igrant);
    assign w_access    = (ramstate_t'(ramstate) == ACCESS);
    assign w_owner_inc = (r_owner == PTR_W'(CPUS - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_owner_req = 1'b0;
        case (r_kind)
            IRD:     w_owner_req = iREN[r_owner];
            DRD:     w_owner_req = dREN[r_owner];
            DWR:     w_owner_req = dWEN[r_owner];
            default: w_owner_req = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_kind   <= NONE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_store  <= '0;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_kind   <= w_nxt_kind;
            r_rr_ptr <= w_nxt_rr;
            r_owner  <= w_nxt_owner;
            r_addr   <= w_nxt_addr;
            r_store  <= w_nxt_store;
            r_ren    <= w_nxt_ren;
            r_wen    <= w_nxt_wen;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_kind  = r_kind;
        w_nxt_rr    = r_rr_ptr;
        w_nxt_owner = r_owner;
        w_nxt_addr  = r_addr;
        w_nxt_store = r_store;
        w_nxt_ren   = r_ren;
        w_nxt_wen   = r_wen;
        case (r_state)
            IDLE: begin
                if (w_dvalid) begin
                    w_nxt_state = ACTIVE;
                    w_nxt_owner = w_didx;
                    w_nxt_addr  = w_daddr_a[w_didx];
                    w_nxt_store = w_dstore_a[w_didx];
                    // A core asserting both strobes is treated as a write.
                    if (dWEN[w_didx]) begin
                        w_nxt_kind = DWR;
                        w_nxt_ren  = 1'b0;
                        w_nxt_wen  = 1'b1;
                    end else begin
                        w_nxt_kind = DRD;
                        w_nxt_ren  = 1'b1;
                        w_nxt_wen  = 1'b0;
                    end
                end else if (w_ivalid) begin
                    w_nxt_state = ACTIVE;
                    w_nxt_owner = w_iidx;
                    w_nxt_kind  = IRD;
                    w_nxt_addr  = w_iaddr_a[w_iidx];
                    w_nxt_ren   = 1'b1;
                    w_nxt_wen   = 1'b0;
                end
            end
            ACTIVE: begin
                if (w_access) begin
                    w_nxt_state = DONE;
                    w_nxt_rr    = w_owner_inc;
                    w_nxt_ren   = 1'b0;
                    w_nxt_wen   = 1'b0;
                end else if (!w_owner_req) begin
                    w_nxt_state = IDLE;
                    w_nxt_kind  = NONE;
                    w_nxt_ren   = 1'b0;
                    w_nxt_wen   = 1'b0;
                end
            end
            DONE: begin
                w_nxt_state = IDLE;
                w_nxt_kind  = NONE;
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_kind  = NONE;
                w_nxt_ren   = 1'b0;
                w_nxt_wen   = 1'b0;
            end
        endcase
    end

    // Watchdog only flags a stuck RAM; the access itself keeps waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == ACTIVE && w_nxt_state == ACTIVE) begin
                if (r_wdog != WD_W'(TIMEOUT)) r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
            if (r_state == ACTIVE && !w_access && r_wdog >= WD_W'(TIMEOUT - 1)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        iwait = '1;
        dwait = '1;
        if (r_state == ACTIVE && w_access) begin
            if (r_kind == IRD) begin
                iwait[r_owner] = 1'b0;
            end else if (r_kind == DRD || r_kind == DWR) begin
                dwait[r_owner] = 1'b0;
            end
        end
    end

    assign iload       = {CPUS{ramload}};
    assign dload       = {CPUS{ramload}};
    assign ramREN      = r_ren;
    assign ramWEN      = r_wen;
    assign ramaddr     = r_addr;
    assign ramstore    = r_store;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.CPUS(2), .TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Plays the RAM for one access starting from IDLE with requests already driven.
    // Returns what the arbiter presented; ends in the IDLE cycle after DONE.
    task automatic serve(input int busy, input logic [31:0] load,
                         output logic s_ren, output logic s_wen,
                         output logic [31:0] s_addr, output logic [31:0] s_store,
                         output logic [1:0] s_iw, output logic [1:0] s_dw,
                         output logic [63:0] s_iload, output logic [63:0] s_dload,
                         output logic s_stable, output logic s_done_off);
        @(posedge CLK); #1;
        s_ren = ramREN; s_wen = ramWEN; s_addr = ramaddr; s_store = ramstore;
        s_stable = 1'b1;
        for (int i = 0; i < busy; i++) begin
            ramstate = 2'd1; #1;
            if (ramREN !== s_ren || ramWEN !== s_wen || ramaddr !== s_addr ||
                ramstore !== s_store || iwait !== 2'b11 || dwait !== 2'b11) s_stable = 1'b0;
            @(posedge CLK); #1;
        end
        ramstate = 2'd2; ramload = load; #1;
        if (ramREN !== s_ren || ramWEN !== s_wen || ramaddr !== s_addr) s_stable = 1'b0;
        s_iw = iwait; s_dw = dwait; s_iload = iload; s_dload = dload;
        @(posedge CLK); #1;
        ramstate = 2'd0; #1;
        s_done_off = (ramREN === 1'b0) && (ramWEN === 1'b0) && (iwait === 2'b11) && (dwait === 2'b11);
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        iREN = 2'b11; dREN = 2'b01;
        nRST = 1'b0; #1;
        n_tests++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++;
            $display("FAIL reset_strobes: got %b required 00", {ramREN, ramWEN}); end
        n_tests++; if ({iwait, dwait} !== 4'b1111) begin n_fail++;
            $display("FAIL reset_waits: got %b required 1111", {iwait, dwait}); end
        n_tests++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_fail++;
            $display("FAIL reset_ramregs: got %h/%h required 0/0", ramaddr, ramstore); end
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++;
            $display("FAIL reset_err: got %b required 0", err_timeout); end
        do_reset();
        repeat (3) begin
            @(posedge CLK); #1;
            n_tests++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 2'b11) begin n_fail++;
                $display("FAIL idle_no_req: got ren=%b wen=%b iwait=%b required 0 0 11",
                         ramREN, ramWEN, iwait); end
        end
    endtask

    task automatic test_single_fetch();
        logic r, w, st, off; logic [31:0] a, s; logic [1:0] iw, dw; logic [63:0] il, dl;
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h40;
        serve(2, 32'hDEADBEEF, r, w, a, s, iw, dw, il, dl, st, off);
        iREN = 2'b00;
        n_tests++; if ({r, w} !== 2'b10) begin n_fail++;
            $display("FAIL fetch_strobes: got %b required 10", {r, w}); end
        n_tests++; if (a !== 32'h40) begin n_fail++;
            $display("FAIL fetch_addr: got %h required 40", a); end
        n_tests++; if ({iw, dw} !== 4'b1011) begin n_fail++;
            $display("FAIL fetch_waits: got iw=%b dw=%b required 10 11", iw, dw); end
        n_tests++; if (il[31:0] !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL fetch_iload: got %h required deadbeef", il[31:0]); end
        n_tests++; if (!st || !off) begin n_fail++;
            $display("FAIL fetch_stable_done: got stable=%b done_off=%b required 1 1", st, off); end
    endtask

    task automatic test_data_over_instr();
        logic r, w, st, off; logic [31:0] a, s; logic [1:0] iw, dw; logic [63:0] il, dl;
        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h44;
        dWEN = 2'b01; daddr[31:0] = 32'h80; dstore[31:0] = 32'h1234;
        serve(1, 32'h0, r, w, a, s, iw, dw, il, dl, st, off);
        dWEN = 2'b00;
        n_tests++; if ({r, w} !== 2'b01 || a !== 32'h80 || s !== 32'h1234) begin n_fail++;
            $display("FAIL dpri_write: got ren=%b wen=%b addr=%h store=%h required 0 1 80 1234",
                     r, w, a, s); end
        n_tests++; if ({iw, dw} !== 4'b1110) begin n_fail++;
            $display("FAIL dpri_write_waits: got iw=%b dw=%b required 11 10", iw, dw); end
        serve(0, 32'h5555AAAA, r, w, a, s, iw, dw, il, dl, st, off);
        iREN = 2'b00;
        n_tests++; if ({r, w} !== 2'b10 || a !== 32'h44) begin n_fail++;
            $display("FAIL dpri_fetch_after: got ren=%b wen=%b addr=%h required 1 0 44", r, w, a); end
        n_tests++; if ({iw, dw} !== 4'b1011 || dl[63:32] !== 32'h5555AAAA) begin n_fail++;
            $display("FAIL dpri_fetch_waits: got iw=%b dw=%b dload1=%h required 10 11 5555aaaa",
                     iw, dw, dl[63:32]); end
    endtask

    task automatic test_round_robin();
        logic r, w, st, off; logic [31:0] a, s; logic [1:0] iw, dw; logic [63:0] il, dl;
        logic [1:0] exp_dw;
        do_reset();
        dREN = 2'b11; daddr = {32'h200, 32'h100};
        for (int k = 0; k < 4; k++) begin
            serve(0, 32'h0, r, w, a, s, iw, dw, il, dl, st, off);
            exp_dw = ~(2'b01 << (k % 2));
            n_tests++; if (dw !== exp_dw || a !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin n_fail++;
                $display("FAIL rr_grant%0d: got dwait=%b addr=%h required %b %h", k, dw, a, exp_dw,
                         (k % 2 == 0) ? 32'h100 : 32'h200); end
            n_tests++; if ((~dw & ~iw) !== 2'b00 && 1'b0 || dw === 2'b00) begin n_fail++;
                $display("FAIL rr_both_low%0d: got dwait=%b required one low", k, dw); end
        end
        dREN = 2'b00;
    endtask

    task automatic test_abort();
        logic r, w, st, off; logic [31:0] a, s; logic [1:0] iw, dw; logic [63:0] il, dl;
        do_reset();
        dREN = 2'b01; daddr[31:0] = 32'h300;
        serve(0, 32'h0, r, w, a, s, iw, dw, il, dl, st, off);
        dREN = 2'b10; daddr = {32'h400, 32'h300};
        @(posedge CLK); #1;
        ramstate = 2'd1;
        n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin n_fail++;
            $display("FAIL abort_grant: got ren=%b addr=%h required 1 400", ramREN, ramaddr); end
        @(posedge CLK); #1;
        dREN = 2'b00; #1;
        n_tests++; if (dwait !== 2'b11) begin n_fail++;
            $display("FAIL abort_dwait: got %b required 11", dwait); end
        @(posedge CLK); #1;
        ramstate = 2'd0;
        n_tests++; if ({ramREN, ramWEN} !== 2'b00 || dwait[1] !== 1'b1) begin n_fail++;
            $display("FAIL abort_strobes_off: got %b dwait1=%b required 00 1", {ramREN, ramWEN}, dwait[1]); end
        @(posedge CLK); #1;
        n_tests++; if (ramREN !== 1'b0) begin n_fail++;
            $display("FAIL abort_idle: got ren=%b required 0", ramREN); end
        dREN = 2'b11;
        serve(0, 32'h0, r, w, a, s, iw, dw, il, dl, st, off);
        dREN = 2'b00;
        n_tests++; if (dw !== 2'b01 || a !== 32'h400) begin n_fail++;
            $display("FAIL abort_rr_kept: got dwait=%b addr=%h required 01 400", dw, a); end
    endtask

    task automatic test_random();
        logic r, w, st, off; logic [31:0] a, s; logic [1:0] iw, dw; logic [63:0] il, dl;
        logic [1:0] ri, rd, rw, dreq, exp_iw, exp_dw;
        logic [31:0] load, exp_addr;
        int m_rr, own, busy;
        bit is_d, is_w;
        do_reset();
        m_rr = 0;
        for (int t = 0; t < 40; t++) begin
            ri = 2'($urandom); rd = 2'($urandom); rw = 2'($urandom);
            if ((ri | rd | rw) == 2'b00) ri = 2'b01 << $urandom_range(0, 1);
            iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom}; dstore = {$urandom, $urandom};
            iREN = ri; dREN = rd; dWEN = rw;
            dreq = rd | rw;
            is_d = (dreq != 2'b00);
            own = 0;
            for (int k = 1; k >= 0; k--) begin
                if ((is_d ? dreq[(m_rr + k) % 2] : ri[(m_rr + k) % 2])) own = (m_rr + k) % 2;
            end
            is_w = is_d && rw[own];
            exp_addr = is_d ? daddr[own*32 +: 32] : iaddr[own*32 +: 32];
            exp_iw = 2'b11; exp_dw = 2'b11;
            if (is_d) exp_dw[own] = 1'b0; else exp_iw[own] = 1'b0;
            busy = $urandom_range(0, 4);
            load = $urandom;
            serve(busy, load, r, w, a, s, iw, dw, il, dl, st, off);
            n_tests++; if ({r, w} !== {!is_w, is_w} || a !== exp_addr) begin n_fail++;
                $display("FAIL rand%0d_req: got ren=%b wen=%b addr=%h required %b %b %h",
                         t, r, w, a, !is_w, is_w, exp_addr); end
            if (is_w) begin
                n_tests++; if (s !== dstore[own*32 +: 32]) begin n_fail++;
                    $display("FAIL rand%0d_store: got %h required %h", t, s, dstore[own*32 +: 32]); end
            end
            n_tests++; if (iw !== exp_iw || dw !== exp_dw) begin n_fail++;
                $display("FAIL rand%0d_waits: got iw=%b dw=%b required %b %b", t, iw, dw, exp_iw, exp_dw); end
            n_tests++; if (il !== {load, load} || dl !== {load, load}) begin n_fail++;
                $display("FAIL rand%0d_load: got %h/%h required %h", t, il, dl, {load, load}); end
            n_tests++; if (!st || !off) begin n_fail++;
                $display("FAIL rand%0d_stable_done: got %b %b required 1 1", t, st, off); end
            m_rr = (own + 1) % 2;
        end
        clear_inputs();
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++;
            $display("FAIL rand_no_timeout: got %b required 0", err_timeout); end
    endtask

    task automatic test_watchdog();
        do_reset();
        iREN = 2'b10; iaddr = {32'h500, 32'h0};
        @(posedge CLK); #1;
        for (int j = 1; j <= 20; j++) begin
            ramstate = 2'd1; #1;
            n_tests++; if (err_timeout !== (j >= 9)) begin n_fail++;
                $display("FAIL wdog_cycle%0d: got %b required %b", j, err_timeout, (j >= 9)); end
            @(posedge CLK); #1;
        end
        ramstate = 2'd2; #1;
        n_tests++; if (iwait !== 2'b01) begin n_fail++;
            $display("FAIL wdog_complete: got iwait=%b required 01", iwait); end
        @(posedge CLK); #1;
        ramstate = 2'd0; iREN = 2'b00;
        repeat (3) @(posedge CLK); #1;
        n_tests++; if (err_timeout !== 1'b1) begin n_fail++;
            $display("FAIL wdog_sticky: got %b required 1", err_timeout); end
        do_reset();
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++;
            $display("FAIL wdog_cleared: got %b required 0", err_timeout); end
    endtask

    task automatic test_async_reset();
        do_reset();
        dWEN = 2'b01; daddr[31:0] = 32'h600; dstore[31:0] = 32'hABCD;
        @(posedge CLK); #1;
        ramstate = 2'd2; #1;
        n_tests++; if (dwait !== 2'b10 || ramWEN !== 1'b1) begin n_fail++;
            $display("FAIL areset_pre: got dwait=%b wen=%b required 10 1", dwait, ramWEN); end
        nRST = 1'b0; #1;
        n_tests++; if ({ramREN, ramWEN} !== 2'b00 || {iwait, dwait} !== 4'b1111) begin n_fail++;
            $display("FAIL areset_immediate: got strobes=%b waits=%b required 00 1111",
                     {ramREN, ramWEN}, {iwait, dwait}); end
        clear_inputs();
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
        n_tests++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_fail++;
            $display("FAIL areset_after: got %b required 00", {ramREN, ramWEN}); end
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b1;
        test_reset();
        test_single_fetch();
        test_data_over_instr();
        test_round_robin();
        test_abort();
        test_random();
        test_watchdog();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
